wb_regfile: RTL and testbench
=============================

WB_REGFILE -- requirements
Module: wb_regfile

Interface
REQ-001 SHALL have parameter DATA_W, default 64, register data width.
REQ-002 SHALL have parameter NREG, default 15, architectural register count; index 4'hF (RNONE) is never written.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  writeback-stage input carries an instruction this cycle.
REQ-006 SHALL have port w_stall  input  1  hold the W stage register.
REQ-007 SHALL have port w_bubble  input  1  load a NOP into the W stage register.
REQ-008 SHALL have port icode  input  4  Y86-64 instruction code.
REQ-009 SHALL have port cond_flag  input  1  condition result for cmovXX.
REQ-010 SHALL have port rA, rB  input  4 each  instruction register specifiers.
REQ-011 SHALL have port valE, valM  input  DATA_W each  ALU result and memory result.
REQ-012 SHALL have port stat_in  input  2  status: AOK=1, HLT=2, ADR=3, INS=4 encoded as 0..3 in that order.
REQ-013 SHALL have ports srcA, srcB, dbg_sel  input  4 each  read-port selectors.
REQ-014 SHALL have ports valA, valB, dbg_val  output  DATA_W each  read data (combinational).
REQ-015 SHALL have port halted  output  1  sticky; a non-AOK status has retired.
REQ-016 SHALL have port retire_cnt  output  32  count of retired instructions.

Function
REQ-017 SHALL decode destinations: icode 2 -> dstE=rB if cond_flag else RNONE; 3, 6 -> dstE=rB; 5 -> dstM=rA; 8, 9, A -> dstE=RSP(4); B -> dstE=RSP, dstM=rA; all others -> both RNONE.
REQ-018 SHALL capture {icode, dstE, dstM, valE, valM, stat} into the W register at a clock edge when in_valid=1, w_stall=0 and w_bubble=0; the W fresh flag is then set.
REQ-019 SHALL load a bubble (icode NOP, dsts RNONE, stat AOK, fresh=0) when w_bubble=1 and w_stall=0, or when in_valid=0 and w_stall=0.
REQ-020 SHALL hold W contents and clear fresh when w_stall=1; w_stall has priority over w_bubble.
REQ-021 SHALL, at the edge after capture, write valE to dstE and valM to dstM when fresh=1, W stat=AOK and halted=0; total latency from input to register-file update is 2 edges.
REQ-022 SHALL, when dstE==dstM (popq %rsp), store valM only.
REQ-023 SHALL forward onto valA/valB/dbg_val: selector equals fresh W dstM -> W valM; else equals fresh W dstE -> W valE; else the register-file value; forwarding obeys the same stat/halted gating as REQ-021.
REQ-024 SHALL return 0 for any selector equal to RNONE or >= NREG.
REQ-025 SHALL set halted at the edge where a fresh W entry with stat != AOK retires; that entry performs no register write.
REQ-026 SHALL, once halted=1, ignore all further writes and retire-count increments until reset.
REQ-027 SHALL increment retire_cnt by 1 per fresh AOK entry retired, wrapping from 2^32-1 to 0.

Reset
REQ-028 SHALL, on reset assertion, immediately clear all registers to 0, set W to bubble, halted=0 and retire_cnt=0, discarding any in-flight W entry.
REQ-029 SHALL accept a capture at the first rising edge after reset deasserts.

Structure
REQ-030 SHALL place icode constants, RNONE, RSP and stat encodings in shared package y86_pkg.
REQ-031 SHALL implement destination decode (REQ-017) as sub-module wb_dst_decode.

Verification
REQ-032 SHALL verify irmovq (icode 3, rB=2, valE=200) -> reg2=200 two edges after input, valB=200 via forwarding one edge after input with srcB=2.
REQ-033 SHALL verify cmovXX (icode 2, rB=3, valE=250) with cond_flag=0 -> reg3 unchanged, and with cond_flag=1 -> reg3=250.
REQ-034 SHALL verify popq (icode B, rA=4, valE=16, valM=99) -> reg4=99; popq with rA=1 -> reg4=16, reg1=99.
REQ-035 SHALL verify w_stall held 3 cycles after mrmovq (icode 5, rA=7, valM=500) -> reg7=500 written once, retire_cnt +1 only.
REQ-036 SHALL verify stat_in=HLT on icode 0 -> halted=1, a following OPq (icode 6, rB=5, valE=7) leaves reg5=0, and reset clears halted and retire_cnt.

Source files
------------

// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions for the writeback / register-file slice.
//   icode_e  : instruction codes
//   stat_e   : 2-bit status encoding (AOK, HLT, ADR, INS -> 0..3)
//   RNONE    : "no register" specifier, never written
//   RSP      : stack pointer register index
//   w_ctrl_t : control half of the W stage register
package y86_pkg;

    typedef enum logic [3:0] {
        IHalt   = 4'h0,
        INop    = 4'h1,
        ICmovxx = 4'h2,
        IIrmovq = 4'h3,
        IRmmovq = 4'h4,
        IMrmovq = 4'h5,
        IOpq    = 4'h6,
        IJxx    = 4'h7,
        ICall   = 4'h8,
        IRet    = 4'h9,
        IPushq  = 4'hA,
        IPopq   = 4'hB
    } icode_e;

    typedef enum logic [1:0] {
        StatAok = 2'd0,
        StatHlt = 2'd1,
        StatAdr = 2'd2,
        StatIns = 2'd3
    } stat_e;

    localparam logic [3:0] RNONE = 4'hF;
    localparam logic [3:0] RSP   = 4'h4;

    typedef struct packed {
        logic [3:0] icode;
        logic [3:0] dst_e;
        logic [3:0] dst_m;
        stat_e      stat;
        logic       fresh;
    } w_ctrl_t;

    localparam w_ctrl_t W_BUBBLE = '{
        icode: INop,
        dst_e: RNONE,
        dst_m: RNONE,
        stat:  StatAok,
        fresh: 1'b0
    };

    // A specifier names a real architectural register.
    function automatic logic is_reg(input logic [3:0] r, input int unsigned nreg);
        return (r != RNONE) && (32'(r) < nreg);
    endfunction

endpackage

// File: rtl/wb_dst_decode.sv
// Destination-register decode for the writeback stage.
//   icode     : instruction code
//   cond_flag : condition outcome, only meaningful for cmovXX
//   rA, rB    : register specifiers from the instruction
//   dst_e     : destination for valE (RNONE when none)
//   dst_m     : destination for valM (RNONE when none)
module wb_dst_decode
    import y86_pkg::*;
(
    input  logic [3:0] icode,
    input  logic       cond_flag,
    input  logic [3:0] rA,
    input  logic [3:0] rB,
    output logic [3:0] dst_e,
    output logic [3:0] dst_m
);

    always_comb begin
        dst_e = RNONE;
        dst_m = RNONE;
        case (icode)
            ICmovxx:              dst_e = cond_flag ? rB : RNONE;
            IIrmovq, IOpq:        dst_e = rB;
            IMrmovq:              dst_m = rA;
            ICall, IRet, IPushq:  dst_e = RSP;
            IPopq: begin
                dst_e = RSP;
                dst_m = rA;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/wb_regfile.sv
// Y86-64 writeback stage register (W) plus architectural register file.
//   clk, reset            : clock; asynchronous active-high reset
//   in_valid              : an instruction is presented this cycle
//   w_stall, w_bubble     : W hold / W load-NOP controls (stall wins)
//   icode, cond_flag      : instruction code and cmov condition
//   rA, rB                : register specifiers
//   valE, valM            : ALU and memory results
//   stat_in               : instruction status
//   srcA, srcB, dbg_sel   : read selectors
//   valA, valB, dbg_val   : read data, forwarded from a live W entry
//   halted                : sticky, a non-AOK status has retired
//   retire_cnt            : count of retired AOK instructions (wraps)
module wb_regfile
    import y86_pkg::*;
#(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned NREG   = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic              w_stall,
    input  logic              w_bubble,
    input  logic [3:0]        icode,
    input  logic              cond_flag,
    input  logic [3:0]        rA,
    input  logic [3:0]        rB,
    input  logic [DATA_W-1:0] valE,
    input  logic [DATA_W-1:0] valM,
    input  logic [1:0]        stat_in,
    input  logic [3:0]        srcA,
    input  logic [3:0]        srcB,
    input  logic [3:0]        dbg_sel,
    output logic [DATA_W-1:0] valA,
    output logic [DATA_W-1:0] valB,
    output logic [DATA_W-1:0] dbg_val,
    output logic              halted,
    output logic [31:0]       retire_cnt
);

    logic [3:0] dec_dst_e;
    logic [3:0] dec_dst_m;

    wb_dst_decode u_dst_decode (
        .icode     (icode),
        .cond_flag (cond_flag),
        .rA        (rA),
        .rB        (rB),
        .dst_e     (dec_dst_e),
        .dst_m     (dec_dst_m)
    );

    w_ctrl_t           w_ctrl_q, w_ctrl_d;
    logic [DATA_W-1:0] w_val_e_q, w_val_e_d;
    logic [DATA_W-1:0] w_val_m_q, w_val_m_d;
    logic              halted_q;
    logic [31:0]       retire_cnt_q;
    logic [DATA_W-1:0] rf_q [NREG];

    // icode rides along in W for debug visibility; no logic consumes it.
    logic unused_w_icode;
    assign unused_w_icode = ^w_ctrl_q.icode;

    // W next state: stall holds the entry but marks it consumed so it
    // can never retire twice.
    always_comb begin
        w_ctrl_d  = w_ctrl_q;
        w_val_e_d = w_val_e_q;
        w_val_m_d = w_val_m_q;
        if (w_stall) begin
            w_ctrl_d.fresh = 1'b0;
        end else if (in_valid && !w_bubble) begin
            w_ctrl_d.icode = icode;
            w_ctrl_d.dst_e = dec_dst_e;
            w_ctrl_d.dst_m = dec_dst_m;
            w_ctrl_d.stat  = stat_e'(stat_in);
            w_ctrl_d.fresh = 1'b1;
            w_val_e_d      = valE;
            w_val_m_d      = valM;
        end else begin
            w_ctrl_d = W_BUBBLE;
        end
    end

    logic commit;
    logic halt_now;
    logic wr_e;
    logic wr_m;

    assign commit   = w_ctrl_q.fresh && (w_ctrl_q.stat == StatAok) && !halted_q;
    assign halt_now = w_ctrl_q.fresh && (w_ctrl_q.stat != StatAok) && !halted_q;
    // popq %rsp: both destinations are the same register, valM wins.
    assign wr_e = commit && is_reg(w_ctrl_q.dst_e, NREG) && (w_ctrl_q.dst_e != w_ctrl_q.dst_m);
    assign wr_m = commit && is_reg(w_ctrl_q.dst_m, NREG);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            w_ctrl_q     <= W_BUBBLE;
            w_val_e_q    <= '0;
            w_val_m_q    <= '0;
            halted_q     <= 1'b0;
            retire_cnt_q <= '0;
            for (int i = 0; i < NREG; i++) begin
                rf_q[i] <= '0;
            end
        end else begin
            w_ctrl_q  <= w_ctrl_d;
            w_val_e_q <= w_val_e_d;
            w_val_m_q <= w_val_m_d;
            if (halt_now) begin
                halted_q <= 1'b1;
            end
            if (commit) begin
                retire_cnt_q <= retire_cnt_q + 32'd1;
            end
            for (int i = 0; i < NREG; i++) begin
                if (wr_m && (w_ctrl_q.dst_m == 4'(i))) begin
                    rf_q[i] <= w_val_m_q;
                end else if (wr_e && (w_ctrl_q.dst_e == 4'(i))) begin
                    rf_q[i] <= w_val_e_q;
                end
            end
        end
    end

    // Raw register-file lookups for the three read ports.
    logic [DATA_W-1:0] rf_a, rf_b, rf_d;

    always_comb begin
        rf_a = '0;
        rf_b = '0;
        rf_d = '0;
        for (int i = 0; i < NREG; i++) begin
            if (srcA == 4'(i)) rf_a = rf_q[i];
            if (srcB == 4'(i)) rf_b = rf_q[i];
            if (dbg_sel == 4'(i)) rf_d = rf_q[i];
        end
    end

    // Forward only what is about to be written, so reads never see an entry
    // that the halt gating would later discard.
    function automatic logic [DATA_W-1:0] fwd(
        input logic [3:0]        sel,
        input logic [DATA_W-1:0] rf_val,
        input logic              live,
        input logic [3:0]        d_e,
        input logic [3:0]        d_m,
        input logic [DATA_W-1:0] v_e,
        input logic [DATA_W-1:0] v_m
    );
        if (!is_reg(sel, NREG)) return '0;
        if (live && (sel == d_m)) return v_m;
        if (live && (sel == d_e)) return v_e;
        return rf_val;
    endfunction

    always_comb begin
        valA    = fwd(srcA, rf_a, commit, w_ctrl_q.dst_e, w_ctrl_q.dst_m, w_val_e_q, w_val_m_q);
        valB    = fwd(srcB, rf_b, commit, w_ctrl_q.dst_e, w_ctrl_q.dst_m, w_val_e_q, w_val_m_q);
        dbg_val = fwd(dbg_sel, rf_d, commit, w_ctrl_q.dst_e, w_ctrl_q.dst_m, w_val_e_q,
                      w_val_m_q);
    end

    assign halted     = halted_q;
    assign retire_cnt = retire_cnt_q;

endmodule

// File: tb/tb_wb_regfile.sv
// Bench for wb_regfile: directed Y86 writeback scenarios with literal
// expectations, plus an architectural model checked on every negedge.
module tb_wb_regfile;

    localparam int unsigned DW = 64;
    localparam int unsigned NR = 15;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          in_valid = 1'b0;
    logic          w_stall = 1'b0;
    logic          w_bubble = 1'b0;
    logic [3:0]    icode = 4'h1;
    logic          cond_flag = 1'b0;
    logic [3:0]    rA = 4'hF;
    logic [3:0]    rB = 4'hF;
    logic [DW-1:0] valE = '0;
    logic [DW-1:0] valM = '0;
    logic [1:0]    stat_in = 2'd0;
    logic [3:0]    srcA = 4'h0;
    logic [3:0]    srcB = 4'h0;
    logic [3:0]    dbg_sel = 4'h0;
    logic [DW-1:0] valA, valB, dbg_val;
    logic          halted;
    logic [31:0]   retire_cnt;

    always #5 clk = ~clk;

    wb_regfile #(.DATA_W(DW), .NREG(NR)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .w_stall    (w_stall),
        .w_bubble   (w_bubble),
        .icode      (icode),
        .cond_flag  (cond_flag),
        .rA         (rA),
        .rB         (rB),
        .valE       (valE),
        .valM       (valM),
        .stat_in    (stat_in),
        .srcA       (srcA),
        .srcB       (srcB),
        .dbg_sel    (dbg_sel),
        .valA       (valA),
        .valB       (valB),
        .dbg_val    (dbg_val),
        .halted     (halted),
        .retire_cnt (retire_cnt)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- architectural model ----------------
    // Machine state = register array + one pending instruction that has
    // been accepted but not yet retired. A read returns what the register
    // will hold once that pending instruction has retired.
    logic [63:0] m_rf [NR];
    logic [63:0] m_nxt [NR];
    logic        m_halted = 1'b0;
    logic [31:0] m_cnt = '0;
    logic        p_fresh = 1'b0;
    logic [3:0]  p_dst_e = 4'hF;
    logic [3:0]  p_dst_m = 4'hF;
    logic [63:0] p_ve = '0;
    logic [63:0] p_vm = '0;
    logic [1:0]  p_stat = 2'd0;

    function automatic void spec_dsts(input logic [3:0] ic, input logic cf, input logic [3:0] ra,
                                      input logic [3:0] rb, output logic [3:0] de,
                                      output logic [3:0] dm);
        de = 4'hF;
        dm = 4'hF;
        if (ic == 4'h2 && cf) de = rb;
        if (ic == 4'h3 || ic == 4'h6) de = rb;
        if (ic == 4'h5) dm = ra;
        if (ic == 4'h8 || ic == 4'h9 || ic == 4'hA || ic == 4'hB) de = 4'h4;
        if (ic == 4'hB) dm = ra;
    endfunction

    function automatic logic [63:0] arch_view(input logic [3:0] sel);
        if (sel == 4'hF || 32'(sel) >= NR) return 64'd0;
        if (p_fresh && p_stat == 2'd0 && !m_halted) begin
            if (sel == p_dst_m) return p_vm;
            if (sel == p_dst_e) return p_ve;
        end
        return m_rf[sel];
    endfunction

    initial begin
        for (int i = 0; i < NR; i++) m_rf[i] = '0;
        forever begin
            @(posedge clk or posedge reset);
            if (reset) begin
                for (int i = 0; i < NR; i++) m_rf[i] = '0;
                m_halted = 1'b0;
                m_cnt    = '0;
                p_fresh  = 1'b0;
            end else begin
                for (int i = 0; i < NR; i++) m_nxt[i] = arch_view(4'(i));
                for (int i = 0; i < NR; i++) m_rf[i] = m_nxt[i];
                if (p_fresh && !m_halted) begin
                    if (p_stat == 2'd0) m_cnt = m_cnt + 32'd1;
                    else m_halted = 1'b1;
                end
                if (w_stall) begin
                    p_fresh = 1'b0;
                end else if (in_valid && !w_bubble) begin
                    p_fresh = 1'b1;
                    spec_dsts(icode, cond_flag, rA, rB, p_dst_e, p_dst_m);
                    p_ve   = valE;
                    p_vm   = valM;
                    p_stat = stat_in;
                end else begin
                    p_fresh = 1'b0;
                end
            end
        end
    end

    // Continuous comparison against the model.
    initial begin
        forever begin
            @(negedge clk);
            check("model valA", valA, arch_view(srcA));
            check("model valB", valB, arch_view(srcB));
            check("model dbg_val", dbg_val, arch_view(dbg_sel));
            check("model halted", {63'd0, halted}, {63'd0, m_halted});
            check("model retire_cnt", {32'd0, retire_cnt}, {32'd0, m_cnt});
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic set_in(input logic [3:0] ic, input logic cf, input logic [3:0] ra,
                          input logic [3:0] rb, input logic [63:0] ve, input logic [63:0] vm,
                          input logic [1:0] st);
        in_valid  = 1'b1;
        icode     = ic;
        cond_flag = cf;
        rA        = ra;
        rB        = rb;
        valE      = ve;
        valM      = vm;
        stat_in   = st;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one instruction, let it retire, stop at the following negedge.
    task automatic run_instr(input logic [3:0] ic, input logic cf, input logic [3:0] ra,
                             input logic [3:0] rb, input logic [63:0] ve, input logic [63:0] vm,
                             input logic [1:0] st);
        #2;
        set_in(ic, cf, ra, rb, ve, vm, st);
        tick();
        in_valid = 1'b0;
        tick();
        @(negedge clk);
    endtask

    // ---------------- directed scenarios ----------------
    initial begin
        repeat (2) tick();
        @(negedge clk);
        check("reset halted", {63'd0, halted}, 64'd0);
        check("reset retire_cnt", {32'd0, retire_cnt}, 64'd0);
        check("reset dbg_val", dbg_val, 64'd0);

        // irmovq $200,%rdx captured on the very first edge after reset release.
        #2;
        reset = 1'b0;
        srcB = 4'h2;
        dbg_sel = 4'h2;
        set_in(4'h3, 1'b0, 4'hF, 4'h2, 64'd200, 64'd0, 2'd0);
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        check("irmovq forwarded valB", valB, 64'd200);
        check("irmovq cnt before retire", {32'd0, retire_cnt}, 64'd0);
        tick();
        @(negedge clk);
        check("irmovq reg2", dbg_val, 64'd200);
        check("irmovq cnt", {32'd0, retire_cnt}, 64'd1);

        // cmovXX not taken, then taken.
        dbg_sel = 4'h3;
        run_instr(4'h2, 1'b0, 4'hF, 4'h3, 64'd250, 64'd0, 2'd0);
        check("cmov nt reg3", dbg_val, 64'd0);
        check("cmov nt cnt", {32'd0, retire_cnt}, 64'd2);
        run_instr(4'h2, 1'b1, 4'hF, 4'h3, 64'd250, 64'd0, 2'd0);
        check("cmov t reg3", dbg_val, 64'd250);

        // popq %rsp: valM wins; popq %rcx: rsp<-valE, rcx<-valM.
        dbg_sel = 4'h4;
        run_instr(4'hB, 1'b0, 4'h4, 4'hF, 64'd16, 64'd99, 2'd0);
        check("popq rsp reg4", dbg_val, 64'd99);
        srcA = 4'h1;
        srcB = 4'h4;
        run_instr(4'hB, 1'b0, 4'h1, 4'hF, 64'd16, 64'd99, 2'd0);
        check("popq reg4", valB, 64'd16);
        check("popq reg1", valA, 64'd99);
        check("popq cnt", {32'd0, retire_cnt}, 64'd5);

        // Write to RNONE is dropped but still retires; RNONE reads as 0.
        srcA = 4'hF;
        run_instr(4'h3, 1'b0, 4'hF, 4'hF, 64'd123, 64'd0, 2'd0);
        check("rnone read", valA, 64'd0);
        check("rnone cnt", {32'd0, retire_cnt}, 64'd6);

        // Bubble discards a presented instruction.
        dbg_sel = 4'h6;
        #2;
        w_bubble = 1'b1;
        set_in(4'h3, 1'b0, 4'hF, 4'h6, 64'd55, 64'd0, 2'd0);
        tick();
        in_valid = 1'b0;
        w_bubble = 1'b0;
        tick();
        @(negedge clk);
        check("bubble reg6", dbg_val, 64'd0);
        check("bubble cnt", {32'd0, retire_cnt}, 64'd6);

        // mrmovq then a 3-cycle stall with a competing instruction on the input.
        dbg_sel = 4'h7;
        #2;
        set_in(4'h5, 1'b0, 4'h7, 4'hF, 64'd0, 64'd500, 2'd0);
        tick();
        set_in(4'h5, 1'b0, 4'h7, 4'hF, 64'd0, 64'd777, 2'd0);
        w_stall = 1'b1;
        @(negedge clk);
        check("stall fwd reg7", dbg_val, 64'd500);
        repeat (2) tick();
        @(negedge clk);
        check("stall mid cnt", {32'd0, retire_cnt}, 64'd7);
        tick();
        w_stall = 1'b0;
        in_valid = 1'b0;
        tick();
        @(negedge clk);
        check("stall reg7", dbg_val, 64'd500);
        check("stall cnt once", {32'd0, retire_cnt}, 64'd7);

        // halt retires, following OPq to %rbp is suppressed.
        dbg_sel = 4'h5;
        #2;
        set_in(4'h0, 1'b0, 4'hF, 4'hF, 64'd0, 64'd0, 2'd1);
        tick();
        set_in(4'h6, 1'b0, 4'h3, 4'h5, 64'd7, 64'd0, 2'd0);
        @(negedge clk);
        check("halt not yet", {63'd0, halted}, 64'd0);
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        check("halted set", {63'd0, halted}, 64'd1);
        check("halted no fwd reg5", dbg_val, 64'd0);
        tick();
        @(negedge clk);
        check("halted reg5", dbg_val, 64'd0);
        check("halted cnt", {32'd0, retire_cnt}, 64'd7);

        // Reset clears everything immediately, without a clock edge.
        srcB = 4'h2;
        #2;
        reset = 1'b1;
        #1;
        check("reset halted clear", {63'd0, halted}, 64'd0);
        check("reset cnt clear", {32'd0, retire_cnt}, 64'd0);
        check("reset reg2 clear", valB, 64'd0);
        tick();
        #2;
        reset = 1'b0;
        dbg_sel = 4'h2;
        run_instr(4'h3, 1'b0, 4'hF, 4'h2, 64'd42, 64'd0, 2'd0);
        check("post reset reg2", dbg_val, 64'd42);
        check("post reset cnt", {32'd0, retire_cnt}, 64'd1);

        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
